// File: rtl/fifo_addr_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO address controller.
//   - FIFO_DEPTH default: the `FIFO_DEPTH macro, or 16 if it is not set.
//   - Occupancy FSM state encodings ST_EMPTY / ST_PART / ST_FULL.
// Optional feature macro used by the top: FIFO_ERR_FLAG_EN (sticky error flags).
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

package fifo_addr_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = `FIFO_DEPTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer register with increment and parallel load.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   inc          advance pointer by one (wraps modulo 2^W)
//   load         load load_val; takes priority over inc
//   load_val     value to load
//   ptr          registered pointer
module fifo_ptr_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset)     ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_addr_ctrl.sv
// Write/read pointer controller for the synchronous FIFO.
// Converts write/read handshakes into RAM enables/addresses, keeps the
// (ADDR_WIDTH+1)-bit pointers for the flag comparator, a registered
// occupancy count and an EMPTY/PART/FULL FSM that gates every access.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_wr_req, i_rd_req         write request / read request
//   i_flush                    drop all entries (requests ignored that cycle)
//   i_err_clr                  clear sticky error flags
//   o_mem_we, o_mem_waddr      RAM write port (combinational)
//   o_mem_re, o_mem_raddr      RAM read port (combinational)
//   o_rd_dvalid                RAM read data valid, one cycle after o_mem_re
//   wr_addr, rd_addr           pointers with wrap bit
//   o_count                    stored entries 0..FIFO_DEPTH
//   o_overflow, o_underflow    sticky error flags
// Configuration macro: FIFO_ERR_FLAG_EN enables the sticky error flags;
// without it they are tied to 0 and i_err_clr is ignored.
import fifo_addr_ctrl_pkg::*;

module fifo_addr_ctrl #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_req,
  input  logic                  i_rd_req,
  input  logic                  i_flush,
  input  logic                  i_err_clr,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  output logic                  o_rd_dvalid,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic [ADDR_WIDTH:0]   rd_addr,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  fifo_state_e   state_q, state_d;
  logic          wr_acc, rd_acc;
  logic [PW-1:0] wr_nxt, rd_nxt;

  // Gating uses the registered state only: no write at full even if a read
  // frees a slot this cycle, no read-through at empty.
  assign wr_acc = i_wr_req & (state_q != ST_FULL)  & ~i_flush;
  assign rd_acc = i_rd_req & (state_q != ST_EMPTY) & ~i_flush;

  assign o_mem_we    = wr_acc;
  assign o_mem_re    = rd_acc;
  assign o_mem_waddr = wr_addr[ADDR_WIDTH-1:0];
  assign o_mem_raddr = rd_addr[ADDR_WIDTH-1:0];

  fifo_ptr_cnt #(.W(PW)) u_wr_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (wr_acc),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_addr)
  );

  // Flush discards everything by snapping the read pointer onto the write pointer.
  fifo_ptr_cnt #(.W(PW)) u_rd_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (rd_acc),
    .load     (i_flush),
    .load_val (wr_addr),
    .ptr      (rd_addr)
  );

  // Count is the registered difference of the next pointers, so it always
  // equals wr_addr - rd_addr.
  assign wr_nxt = wr_addr + PW'(wr_acc);
  assign rd_nxt = i_flush ? wr_addr : rd_addr + PW'(rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      o_count     <= '0;
      o_rd_dvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_count     <= wr_nxt - rd_nxt;
      o_rd_dvalid <= rd_acc;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (wr_acc) state_d = ST_PART;
        ST_PART: begin
          if (wr_acc && !rd_acc && o_count == PW'(FIFO_DEPTH - 1))
            state_d = ST_FULL;
          else if (rd_acc && !wr_acc && o_count == PW'(1))
            state_d = ST_EMPTY;
        end
        ST_FULL:  if (rd_acc) state_d = ST_PART;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  // Set has priority over a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_req && state_q == ST_FULL) o_overflow <= 1'b1;
      else if (i_err_clr)                 o_overflow <= 1'b0;
      if (i_rd_req && state_q == ST_EMPTY) o_underflow <= 1'b1;
      else if (i_err_clr)                  o_underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule
